hazard_forward_unit: RTL and testbench



---
 rtl/hazard_forward_unit.sv | 109 ++++++++++
 tb/tb_hazard_forward_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding between ID and EX.
// A shift-register scoreboard tracks in-flight producers; the youngest match is forwarded.
module hazard_forward_unit #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter bit FWD_EN   = 1'b1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             flush,
  output logic [SEL_W-1:0] rs1_sel,
  output logic [SEL_W-1:0] rs2_sel,
  output logic             stall,
  output logic             issue,
  output logic [31:0]      stall_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } entry_t;

  typedef entry_t sb_t [DEPTH];

  sb_t sb;
  sb_t sb_next;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       rs1_used, rs2_used, writes_rd, is_load;
  logic       rs1_stall, rs2_stall;
  logic       unused_bits;

  assign opcode = id_inst[6:0];
  assign rd     = id_inst[11:7];
  assign rs1    = id_inst[19:15];
  assign rs2    = id_inst[24:20];
  assign unused_bits = ^{id_inst[31:25], id_inst[14:12]};

  // A source reading x0 never creates a dependency, so it is folded into "used".
  assign rs1_used  = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL}) && (rs1 != 5'd0);
  assign rs2_used  = (opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH}) && (rs2 != 5'd0);
  assign writes_rd = !(opcode inside {OPC_STORE, OPC_BRANCH, OPC_SYSTEM}) && (rd != 5'd0);
  assign is_load   = (opcode == OPC_LOAD);

  // Scan oldest to youngest so the lowest-index (youngest) match is the one that sticks.
  function automatic void lookup(input sb_t tbl, input logic used, input logic [4:0] rs,
                                 output logic [SEL_W-1:0] sel, output logic stl);
    sel = '0;
    stl = 1'b0;
    if (used) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (tbl[k].valid && (tbl[k].rd == rs)) begin
          if (!FWD_EN || (tbl[k].is_load && (k < LOAD_LAT))) begin
            stl = 1'b1;
            sel = '0;
          end else begin
            stl = 1'b0;
            sel = SEL_W'(k + 1);
          end
        end
      end
    end
  endfunction

  always_comb begin
    lookup(sb, rs1_used, rs1, rs1_sel, rs1_stall);
    lookup(sb, rs2_used, rs2, rs2_sel, rs2_stall);
  end

  assign stall = id_valid & (rs1_stall | rs2_stall);
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    // NOTE: every element gets an unconditional value before any qualification, so no latch is inferred.
    sb_next[0] = issue ? '{valid: writes_rd, rd: rd, is_load: is_load} : '0;
    for (int k = 1; k < DEPTH; k++) begin
      sb_next[k] = sb[k-1];
      // The instruction leaving EX on a flush is squashed and must not be forwarded later.
      if ((k == 1) && flush) sb_next[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every scoreboard entry is reset; a stale valid bit would forward garbage.
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the shift a true one-cycle move per entry.
      sb <= sb_next;
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: three configurations share stimulus; a queue-based model checks all of them,
// and a directed vector table pins the default configuration's behaviour.
module tb_hazard_forward_unit;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011,
                         OP_SYS = 7'b1110011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int CFG_DEPTH [3] = '{3, 3, 1};
  localparam int CFG_LL    [3] = '{2, 2, 0};
  localparam int CFG_FWD   [3] = '{1, 0, 1};

  logic        clk, rst, id_valid, flush;
  logic [31:0] id_inst;
  logic [1:0]  rs1_sel_a, rs2_sel_a, rs1_sel_b, rs2_sel_b;
  logic [0:0]  rs1_sel_c, rs2_sel_c;
  logic        stall_a, stall_b, stall_c, issue_a, issue_b, issue_c;
  logic [31:0] stall_cnt_a, stall_cnt_b, stall_cnt_c;

  hazard_forward_unit #(.DEPTH(3), .LOAD_LAT(2), .FWD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .rs1_sel(rs1_sel_a), .rs2_sel(rs2_sel_a), .stall(stall_a), .issue(issue_a),
    .stall_cnt(stall_cnt_a));

  hazard_forward_unit #(.DEPTH(3), .LOAD_LAT(2), .FWD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .rs1_sel(rs1_sel_b), .rs2_sel(rs2_sel_b), .stall(stall_b), .issue(issue_b),
    .stall_cnt(stall_cnt_b));

  hazard_forward_unit #(.DEPTH(1), .LOAD_LAT(0), .FWD_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .rs1_sel(rs1_sel_c), .rs2_sel(rs2_sel_c), .stall(stall_c), .issue(issue_c),
    .stall_cnt(stall_cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int r1, input int r2);
    return {7'b0, 5'(r2), 5'(r1), 3'b0, 5'(rd), op};
  endfunction

  // ---------------- reference model: in-flight producers, youngest first ----------------
  typedef struct { bit v; bit [4:0] rd; bit ld; } m_ent_t;
  m_ent_t      mq [3][$];
  bit [31:0]   m_cnt [3];
  bit          m_known = 1'b0;

  function automatic void m_decode(input logic [31:0] ins, output bit u1, output bit u2,
                                   output bit wr, output bit ld);
    bit [6:0] op;
    op = ins[6:0];
    u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    u2 = (op == OP_R || op == OP_ST || op == OP_BR);
    wr = !(op == OP_ST || op == OP_BR || op == OP_SYS) && (ins[11:7] != 5'd0);
    ld = (op == OP_LD);
  endfunction

  function automatic void src_eval(input int c, input bit used, input bit [4:0] rs,
                                   output bit st, output int sel);
    bit found;
    st = 1'b0; sel = 0; found = 1'b0;
    if (used && rs != 5'd0) begin
      for (int k = 0; k < mq[c].size(); k++) begin
        if (!found && mq[c][k].v && mq[c][k].rd == rs) begin
          found = 1'b1;
          if (CFG_FWD[c] == 0 || (mq[c][k].ld && k < CFG_LL[c])) st = 1'b1;
          else sel = k + 1;
        end
      end
    end
  endfunction

  function automatic void model_eval(input int c, output bit st, output bit iss,
                                     output int s1, output int s2);
    bit u1, u2, wr, ld, st1, st2;
    m_decode(id_inst, u1, u2, wr, ld);
    src_eval(c, u1, id_inst[19:15], st1, s1);
    src_eval(c, u2, id_inst[24:20], st2, s2);
    st  = (id_valid === 1'b1) && (st1 || st2);
    iss = (id_valid === 1'b1) && !st && (flush !== 1'b1);
  endfunction

  task automatic model_update();
    bit st, iss, u1, u2, wr, ld;
    int s1, s2;
    m_ent_t e;
    for (int c = 0; c < 3; c++) begin
      if (rst === 1'b1) begin
        mq[c].delete();
        m_cnt[c] = '0;
      end else begin
        model_eval(c, st, iss, s1, s2);
        m_decode(id_inst, u1, u2, wr, ld);
        if (st && m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c] = m_cnt[c] + 1;
        e.v = iss && wr; e.rd = id_inst[11:7]; e.ld = ld;
        mq[c].push_front(e);
        if (flush === 1'b1 && mq[c].size() > 1) begin
          e = mq[c][1];
          e.v = 1'b0;
          mq[c][1] = e;
        end
        while (mq[c].size() > CFG_DEPTH[c]) void'(mq[c].pop_back());
      end
    end
    if (rst === 1'b1) m_known = 1'b1;
  endtask

  task automatic dut_out(input int c, output logic [31:0] s1, output logic [31:0] s2,
                         output logic [31:0] cnt, output logic st, output logic iss);
    case (c)
      0: begin s1 = 32'(rs1_sel_a); s2 = 32'(rs2_sel_a); cnt = stall_cnt_a; st = stall_a; iss = issue_a; end
      1: begin s1 = 32'(rs1_sel_b); s2 = 32'(rs2_sel_b); cnt = stall_cnt_b; st = stall_b; iss = issue_b; end
      default: begin s1 = 32'(rs1_sel_c); s2 = 32'(rs2_sel_c); cnt = stall_cnt_c; st = stall_c; iss = issue_c; end
    endcase
  endtask

  task automatic model_check_all();
    logic [31:0] s1, s2, cnt;
    logic        st, iss;
    bit          m_st, m_iss;
    int          m_s1, m_s2;
    if (!m_known) return;
    for (int c = 0; c < 3; c++) begin
      dut_out(c, s1, s2, cnt, st, iss);
      model_eval(c, m_st, m_iss, m_s1, m_s2);
      check($sformatf("cfg%0d_stall", c), 32'(st), 32'(m_st));
      check($sformatf("cfg%0d_issue", c), 32'(iss), 32'(m_iss));
      check($sformatf("cfg%0d_stall_cnt", c), cnt, m_cnt[c]);
      if (!m_st) begin
        check($sformatf("cfg%0d_rs1_sel", c), s1, 32'(m_s1));
        check($sformatf("cfg%0d_rs2_sel", c), s2, 32'(m_s2));
      end
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
  task automatic apply(input bit r, input bit v, input bit f, input logic [31:0] ins);
    rst = r; id_valid = v; flush = f; id_inst = ins;
    #1;
  endtask

  task automatic finish_cycle();
    model_check_all();
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, NOP);
      finish_cycle();
    end
  endtask

  // ---------------- directed vector table (default configuration) ----------------
  typedef struct {
    bit r, v, f;
    logic [31:0] ins;
    bit chk;
    int e1, e2;
    bit es, ei;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit v, input bit f, input logic [31:0] ins,
                              input bit chk, input int e1, input int e2, input bit es, input bit ei);
    vec_t x;
    x.r = r; x.v = v; x.f = f; x.ins = ins; x.chk = chk;
    x.e1 = e1; x.e2 = e2; x.es = es; x.ei = ei;
    return x;
  endfunction

  function automatic logic [6:0] pick_op(input int i);
    case (i)
      0: return OP_R;   1: return OP_IMM; 2: return OP_LD;    3: return OP_ST;
      4: return OP_BR;  5: return OP_LUI; 6: return OP_AUIPC; 7: return OP_JAL;
      8: return OP_JALR; default: return OP_SYS;
    endcase
  endfunction

  vec_t vecs[$];
  int   n_stall_rows;
  logic [31:0] add8;

  initial begin
    vecs.push_back(mk(1, 1, 0, enc(OP_R, 1, 2, 3), 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, enc(OP_R, 1, 2, 3), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 1, 2, 3), 1, 0, 0, 0, 1));
    // ALU back-to-back, then with a bubble in between
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 5, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 6, 5, 5), 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 5, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, NOP, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 6, 5, 5), 1, 2, 2, 0, 1));
    // load-use: two stall cycles, then forward from entry 2
    vecs.push_back(mk(0, 1, 0, enc(OP_LD, 7, 2, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 8, 7, 0), 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 8, 7, 0), 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 8, 7, 0), 1, 3, 0, 0, 1));
    // youngest producer wins
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 3, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 3, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 4, 3, 3), 1, 1, 1, 0, 1));
    // no-rd producers and unused sources
    vecs.push_back(mk(0, 1, 0, enc(OP_ST, 0, 2, 9), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 10, 9, 9), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 0, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 1, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 11, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, enc(OP_LUI, 12, 11, 0), 1, 0, 0, 0, 1));
    // flush squashes the EX producer
    vecs.push_back(mk(0, 0, 0, NOP, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, NOP, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_IMM, 12, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, enc(OP_R, 13, 12, 0), 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 14, 12, 0), 1, 0, 0, 0, 1));
    // flush together with a load-use stall
    vecs.push_back(mk(0, 1, 0, enc(OP_LD, 15, 0, 0), 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, enc(OP_R, 16, 15, 0), 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, enc(OP_R, 16, 15, 0), 1, 0, 0, 0, 1));

    n_stall_rows = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].f, vecs[i].ins);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_stall", i), 32'(stall_a), 32'(vecs[i].es));
        check($sformatf("vec%0d_issue", i), 32'(issue_a), 32'(vecs[i].ei));
        if (!vecs[i].es) begin
          check($sformatf("vec%0d_rs1_sel", i), 32'(rs1_sel_a), 32'(vecs[i].e1));
          check($sformatf("vec%0d_rs2_sel", i), 32'(rs2_sel_a), 32'(vecs[i].e2));
        end else n_stall_rows++;
      end
      finish_cycle();
    end
    check("table_stall_cnt", stall_cnt_a, 32'(n_stall_rows));

    // Load-use without forwarding: three stall cycles, then sel 0.
    add8 = enc(OP_R, 8, 7, 0);
    drain();
    apply(0, 1, 0, enc(OP_LD, 7, 2, 0));
    finish_cycle();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, add8);
      check($sformatf("nofwd_stall_%0d", i), 32'(stall_b), (i < 3) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("nofwd_rs1_sel", 32'(rs1_sel_b), 32'd0);
        check("nofwd_rs2_sel", 32'(rs2_sel_b), 32'd0);
      end
      if (i == 0) begin
        check("depth1_load_stall", 32'(stall_c), 32'd0);
        check("depth1_load_sel", 32'(rs1_sel_c), 32'd1);
      end
      finish_cycle();
    end

    // Reset in the middle of a load-use stall.
    drain();
    apply(0, 1, 0, enc(OP_LD, 7, 2, 0));
    finish_cycle();
    apply(0, 1, 0, add8);
    check("pre_reset_stall", 32'(stall_a), 32'd1);
    finish_cycle();
    apply(1, 1, 0, add8);
    finish_cycle();
    apply(0, 1, 0, add8);
    check("post_reset_stall", 32'(stall_a), 32'd0);
    check("post_reset_sel", 32'(rs1_sel_a), 32'd0);
    check("post_reset_issue", 32'(issue_a), 32'd1);
    check("post_reset_cnt", stall_cnt_a, 32'd0);
    finish_cycle();

    // Saturation of the stall counter from a preloaded value.
    drain();
    force dut_a.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut_a.stall_cnt;
    m_cnt[0] = 32'hFFFF_FFFE;
    apply(0, 1, 0, enc(OP_LD, 7, 2, 0));
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, add8);
      if (i > 0) check($sformatf("sat_cnt_%0d", i), stall_cnt_a, 32'hFFFF_FFFF);
      finish_cycle();
    end
    apply(0, 0, 0, NOP);
    check("sat_cnt_hold", stall_cnt_a, 32'hFFFF_FFFF);
    finish_cycle();

    // Randomized traffic against the model for all three configurations.
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
            enc(pick_op($urandom_range(0, 9)), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7)));
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
